iter_muldiv_ctrl: RTL
=====================

Name: iter_muldiv_ctrl

Overview:
- Multi-cycle sequencer for the unsigned RV32M-subset operations MUL, MULHU, DIVU and REMU.
- Time-multiplexes one shared (N+1)-bit ripple-carry adder instance (carry-in tied 0) across a negate step and N iteration steps.
- Sits beside the single-cycle ALU; the core stalls on busy and captures result on done.

Parameters:
N, 32, operand/result width; iteration count equals N.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE or DONE.
op  input  2  00=MUL (low product), 01=MULHU (high product), 10=DIVU (quotient), 11=REMU (remainder).
a  input  N  multiplicand/dividend; latched on accepted start.
b  input  N  multiplier/divisor; latched on accepted start.
busy  output  1  high in PREP and RUN.
done  output  1  one-cycle pulse; result valid.
result  output  N  selected result; holds until the next completion.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, result=0; all internal registers cleared. Applies at any point, including mid-RUN. No partial result is ever emitted.
- States and transitions:
  - IDLE: accept start=1.
  - PREP: one cycle.
  - RUN: N cycles, counter 0..N-1.
  - DONE: one cycle, then IDLE, or PREP if start=1.
  - start in PREP/RUN is ignored; no queuing.
- Accept edge: latch op, a, b. Set cnt=0.
- PREP, divide ops:
  - Adder computes negb = ~{1'b0,b} + 1 (N+1 bits).
  - If b==0: skip RUN, go to DONE. DIVU result=all ones; REMU result=latched a (RISC-V semantics).
- PREP, multiply ops:
  - Initialize hi=0 (N+1 bits) and lo=a.
  - No adder use.
- RUN, multiply (shift-add), each step:
  - sum = hi + (lo[0] ? {0,b} : 0) via the shared adder.
  - Then {hi,lo} = {sum,lo} >> 1 (logical).
  - After N steps: low product = lo, high product = hi[N-1:0].
- RUN, divide (restoring), each step:
  - {rem,q} <<= 1.
  - trial = rem_shifted + negb via the shared adder.
  - If trial[N]==0: rem=trial, q[0]=1. Else rem unchanged, q[0]=0.
  - rem is N+1 bits and initializes to 0; q initializes to a.
  - After N steps: quotient=q, remainder=rem[N-1:0].
- Adder sharing: exactly one adder instance. Its operand mux is selected by state/op. No other adders or subtractors.
- DONE:
  - result register loaded on the edge entering DONE.
  - done=1 and busy=0 for exactly that cycle.
- Latency:
  - Normal case: done high in the cycle after the (N+2)-th rising edge, counting the start-sampling edge as edge 1. This is 34 edges for N=32.
  - Divide-by-zero: done after edge 2.
- Back-to-back: start=1 while in DONE is accepted on the exit edge. done is then low the next cycle.
- Operand inputs may change freely after acceptance without affecting the operation.

Test Plan:
1. Reset, then start with op=00, a=7, b=6 -> busy high for 33 cycles; done pulses once after edge 34 with result=42; result holds 42 afterwards.
2. op=01, a=b=0xFFFFFFFF -> result=0xFFFFFFFE. Repeat with op=00 -> result=0x00000001.
3. op=10, a=100, b=7 -> result=14. op=11 with the same operands -> result=2. Also a=5, b=9, op=10/11 -> 0/5.
4. op=10 and op=11 with a=0x12345678, b=0 -> done after edge 2, results 0xFFFFFFFF and 0x12345678. busy is high for only 1 cycle.
5. Start MUL 3*4; pulse start with op=10, a=9, b=3 during RUN; toggle a and b mid-run -> result=12 with only one done pulse. Then hold start=1 in DONE with DIVU 9/3 -> second done 34 edges later with result=3.
6. Assert rst=0 asynchronously mid-RUN (cnt≈15) -> busy, done and result=0 immediately. After release there is no done until a new start; a fresh 7*6 yields 42.

Source files
------------

// File: rtl/iter_muldiv_ctrl.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer built around one shared N+1-bit adder.
// Latency: done pulses after N+2 rising edges counted from the accepting edge (2 edges on divide-by-zero).
// Backpressure: start is only taken in IDLE/DONE; busy flags PREP/RUN and requests made then are dropped.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start, op, a, b request, operation select (00 MUL, 01 MULHU, 10 DIVU, 11 REMU), operands
//   busy, done      operation in flight; one-cycle completion pulse
//   result          selected result, held until the next completion
module iter_muldiv_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int W  = N + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_DONE} state_t;

    state_t        state_q;
    logic [1:0]    op_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [W-1:0]  negb_q;   // two's complement of {0,b}, formed once in PREP
    logic [W-1:0]  hi_q;     // product high half (MUL) / partial remainder (DIV)
    logic [N-1:0]  lo_q;     // multiplier bits (MUL) / dividend-then-quotient (DIV)
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  result_q;
    logic          busy_q;
    logic          done_q;

    // Shared adder and its operand mux
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic [W-1:0]  add_sum;
    logic [W-1:0]  rem_sh;

    logic [W-1:0]  hi_d;
    logic [N-1:0]  lo_d;
    logic [N-1:0]  res_d;

    always_comb begin
        rem_sh = {hi_q[N-1:0], lo_q[N-1]};
        add_a  = '0;
        add_b  = '0;
        if (state_q == S_PREP) begin
            add_a = ~{1'b0, b_q};
            add_b = W'(1);
        end else if (op_q[1]) begin
            add_a = rem_sh;
            add_b = negb_q;
        end else begin
            add_a = hi_q;
            add_b = lo_q[0] ? {1'b0, b_q} : '0;
        end
    end

    assign add_sum = add_a + add_b;

    // One iteration step; on the final step these are also the finished values.
    always_comb begin
        if (op_q[1]) begin
            // Sign bit of the trial subtraction set means the divisor did not fit.
            hi_d = add_sum[N] ? rem_sh : add_sum;
            lo_d = {lo_q[N-2:0], ~add_sum[N]};
        end else begin
            hi_d = {1'b0, add_sum[N:1]};
            lo_d = {add_sum[0], lo_q[N-1:1]};
        end
        case (op_q)
            2'b00:   res_d = lo_d;
            2'b01:   res_d = hi_d[N-1:0];
            2'b10:   res_d = lo_d;
            default: res_d = hi_d[N-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            negb_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (op_q[1] && (b_q == '0)) begin
                        // Divide by zero: quotient all ones, remainder is the dividend.
                        result_q <= op_q[0] ? a_q : '1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        if (op_q[1]) begin
                            negb_q <= add_sum;
                        end
                        hi_q    <= '0;
                        lo_q    <= a_q;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        result_q <= res_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
